// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: logical segment patterns
// ({g,f,e,d,c,b,a}, active-high) and the digit-slot encoding.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    SLOT_0 = 2'd0,
    SLOT_1 = 2'd1,
    SLOT_2 = 2'd2
  } slot_e;

  // Slot sequence 0 -> 1 -> 2 -> 0; the unused encoding recovers to slot 0.
  function automatic slot_e next_slot(input slot_e s);
    case (s)
      SLOT_0:  return SLOT_1;
      SLOT_1:  return SLOT_2;
      default: return SLOT_0;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD-to-seven-segment decoder with a blank override.
// Codes 10..15 show a dash so a corrupt digit is visible rather than hidden.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  input  logic             i_blank,
  output logic [SEG_W-1:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    if (!i_blank) begin
      case (i_bcd)
        4'd0:    o_seg_c = SEG_0;
        4'd1:    o_seg_c = SEG_1;
        4'd2:    o_seg_c = SEG_2;
        4'd3:    o_seg_c = SEG_3;
        4'd4:    o_seg_c = SEG_4;
        4'd5:    o_seg_c = SEG_5;
        4'd6:    o_seg_c = SEG_6;
        4'd7:    o_seg_c = SEG_7;
        4'd8:    o_seg_c = SEG_8;
        4'd9:    o_seg_c = SEG_9;
        default: o_seg_c = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes three BCD digits onto a shared seven-segment bus with
// per-digit anode strobes, frame-coherent snapshot and inter-slot dead time.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEAD       = 4,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [BCD_W-1:0]      CNT1,
  input  logic [BCD_W-1:0]      CNT2,
  input  logic [BCD_W-1:0]      CNT3,
  output logic [SEG_W-1:0]      SEG,
  output logic [NUM_DIGITS-1:0] AN,
  output logic                  FRAME
);

  localparam int unsigned             PS_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PS_W-1:0]         PS_LAST = PS_W'(SCAN_DIV - 1);
  localparam logic [SEG_W-1:0]        SEG_OFF = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0]   AN_OFF  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                           : {NUM_DIGITS{1'b0}};

  logic [PS_W-1:0]       r_ps;
  slot_e                 r_idx;
  logic [BCD_W-1:0]      r_s1, r_s2, r_s3;
  logic                  r_frame;
  logic [NUM_DIGITS-1:0] r_an;
  logic [SEG_W-1:0]      r_seg;

  logic                  w_ps_wrap;
  logic                  w_frame_start;
  logic                  w_dead;
  logic [BCD_W-1:0]      w_d1, w_d2, w_d3;
  logic                  w_blank2, w_blank3;
  logic [BCD_W-1:0]      w_code;
  logic                  w_blank;
  logic [SEG_W-1:0]      w_seg_dec;
  logic [SEG_W-1:0]      w_seg_log;
  logic [NUM_DIGITS-1:0] w_an_log;

  assign w_ps_wrap     = (r_ps == PS_LAST);
  assign w_frame_start = (r_ps == '0) && (r_idx == SLOT_0);
  assign w_dead        = ({1'b0, r_ps} < (PS_W + 1)'(DEAD));

  // At frame start the digits being captured are shown directly, so with no
  // dead time the first lit cycle of slot 0 already uses the new frame's value.
  assign w_d1 = w_frame_start ? CNT1 : r_s1;
  assign w_d2 = w_frame_start ? CNT2 : r_s2;
  assign w_d3 = w_frame_start ? CNT3 : r_s3;

  assign w_blank3 = BLANK_LZ && (w_d3 == '0);
  assign w_blank2 = w_blank3 && (w_d2 == '0);

  always_comb begin
    w_code  = w_d1;
    w_blank = 1'b0;
    case (r_idx)
      SLOT_1: begin
        w_code  = w_d2;
        w_blank = w_blank2;
      end
      SLOT_2: begin
        w_code  = w_d3;
        w_blank = w_blank3;
      end
      default: ;
    endcase
  end

  bcd_to_seg7 u_dec (
    .i_bcd   (w_code),
    .i_blank (w_blank),
    .o_seg_c (w_seg_dec)
  );

  assign w_seg_log = w_dead ? SEG_BLANK : w_seg_dec;
  assign w_an_log  = w_dead ? '0 : (NUM_DIGITS'(1) << r_idx);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ps    <= '0;
      r_idx   <= SLOT_0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      r_frame <= 1'b0;
      r_an    <= AN_OFF;
      r_seg   <= SEG_OFF;
    end else begin
      r_ps <= w_ps_wrap ? '0 : r_ps + PS_W'(1);
      if (w_ps_wrap) r_idx <= next_slot(r_idx);
      if (w_frame_start) begin
        r_s1 <= CNT1;
        r_s2 <= CNT2;
        r_s3 <= CNT3;
      end
      r_frame <= w_frame_start;
      r_an    <= ACTIVE_LOW ? ~w_an_log  : w_an_log;
      r_seg   <= ACTIVE_LOW ? ~w_seg_log : w_seg_log;
    end
  end

  assign SEG   = r_seg;
  assign AN    = r_an;
  assign FRAME = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: three driver instances (low-active with and without
// blanking, high-active) share stimulus; a per-frame scoreboard predicts outputs.
module tb_seg7_scan_driver;

  localparam int unsigned SD = 8;
  localparam int unsigned DT = 2;
  localparam int unsigned FR = 3 * SD;
  localparam logic [32:0] RST_OBS = {3'b111, 7'h7F, 1'b0, 3'b111, 7'h7F, 1'b0, 3'b000, 7'h00, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] c1 = 4'd0, c2 = 4'd0, c3 = 4'd0;
  logic [6:0] seg_a, seg_n, seg_h;
  logic [2:0] an_a, an_n, an_h;
  logic       fr_a, fr_n, fr_h;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] q[$];

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(SD), .DEAD(DT), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
    .CLK(clk), .RESET(rst), .CNT1(c1), .CNT2(c2), .CNT3(c3),
    .SEG(seg_a), .AN(an_a), .FRAME(fr_a));

  seg7_scan_driver #(.SCAN_DIV(SD), .DEAD(DT), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut_nb (
    .CLK(clk), .RESET(rst), .CNT1(c1), .CNT2(c2), .CNT3(c3),
    .SEG(seg_n), .AN(an_n), .FRAME(fr_n));

  seg7_scan_driver #(.SCAN_DIV(SD), .DEAD(DT), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)) dut_ah (
    .CLK(clk), .RESET(rst), .CNT1(c1), .CNT2(c2), .CNT3(c3),
    .SEG(seg_h), .AN(an_h), .FRAME(fr_h));

  function automatic logic [32:0] obs();
    return {an_a, seg_a, fr_a, an_n, seg_n, fr_n, an_h, seg_h, fr_h};
  endfunction

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Expected output k cycles after a frame-start edge, for digits a/b/cc snapped there.
  function automatic logic [32:0] exp_at(input int k, input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] cc);
    int slot;
    int ps;
    logic lit, f;
    logic [3:0] dg;
    logic [2:0] an;
    logic [6:0] sb, sn;
    slot = k / SD;
    ps   = k % SD;
    lit  = (ps >= DT);
    f    = (k == 0);
    dg   = (slot == 0) ? a : (slot == 1) ? b : cc;
    an   = lit ? 3'(1 << slot) : 3'b000;
    sn   = lit ? dec(dg) : 7'h00;
    sb   = sn;
    if (slot == 2 && cc == 4'd0) sb = 7'h00;
    if (slot == 1 && cc == 4'd0 && b == 4'd0) sb = 7'h00;
    return {~an, ~sb, f, ~an, ~sn, f, an, sb, f};
  endfunction

  function automatic void push_frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] cc);
    for (int k = 0; k < FR; k++) q.push_back(exp_at(k, a, b, cc));
  endfunction

  task automatic test_reset();
    logic [32:0] e;
    rst = 1'b1; c1 = 4'd1; c2 = 4'd2; c3 = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 2) rst = 1'b0;
      n_tests++;
      if (obs() !== RST_OBS) begin
        n_fail++;
        $display("FAIL reset_hold i=%0d got=%h exp=%h", i, obs(), RST_OBS);
      end
    end
    push_frame(c1, c2, c3);
    for (int k = 0; k < FR; k++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset_first_frame k=%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  task automatic test_scan_order();
    logic [32:0] e;
    c1 = 4'd5; c2 = 4'd2; c3 = 4'd9;
    push_frame(c1, c2, c3);
    push_frame(c1, c2, c3);
    for (int k = 0; k < 2 * FR; k++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL scan_order k=%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  task automatic test_blanking();
    logic [32:0] e;
    logic [11:0] pats [4];
    pats[0] = {4'd7, 4'd0, 4'd0};
    pats[1] = {4'd0, 4'd0, 4'd0};
    pats[2] = {4'd0, 4'd0, 4'd4};
    pats[3] = {4'd1, 4'hA, 4'd0};
    for (int p = 0; p < 4; p++) begin
      {c1, c2, c3} = pats[p];
      push_frame(c1, c2, c3);
      for (int k = 0; k < FR; k++) begin
        @(posedge clk); #1;
        e = q.pop_front();
        n_tests++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL blanking p=%0d k=%0d got=%h exp=%h", p, k, obs(), e);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [32:0] e;
    c1 = 4'd3; c2 = 4'd1; c3 = 4'd2;
    push_frame(c1, c2, c3);
    for (int k = 0; k < FR; k++) begin
      @(posedge clk); #1;
      if (k == SD + 2) c1 = 4'd8;
      e = q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL snapshot_old k=%0d got=%h exp=%h", k, obs(), e);
      end
    end
    push_frame(c1, c2, c3);
    for (int k = 0; k < FR; k++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL snapshot_new k=%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [32:0] e;
    c1 = 4'd5; c2 = 4'd6; c3 = 4'd7;
    push_frame(c1, c2, c3);
    // Stop after sample k=12: the state now holds slot 1, PS = 5.
    for (int k = 0; k <= SD + 4; k++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL pre_reset k=%0d got=%h exp=%h", k, obs(), e);
      end
    end
    q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (obs() !== RST_OBS) begin
      n_fail++;
      $display("FAIL reset_mid_off got=%h exp=%h", obs(), RST_OBS);
    end
    c1 = 4'd9; c2 = 4'd0; c3 = 4'd1;
    push_frame(c1, c2, c3);
    for (int k = 0; k < FR; k++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL reset_mid_restart k=%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_blanking();
    test_snapshot();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Downstream consumer of the three-digit BCD up/down counter: time-multiplexes its three digit outputs (CNT1 = ones, CNT2 = tens, CNT3 = hundreds) onto one shared seven-segment bus with per-digit anode strobes. The block contains the scan prescaler, the digit-slot sequencer and a frame-coherent snapshot of the digits. It also performs BCD-to-segment decoding with leading-zero blanking and a dead time between digit slots to suppress ghosting.

## Interface
- SCAN_DIV, default 50000: clock cycles per digit slot; must be ≥ DEAD+1 and ≥ 2.
- DEAD, default 4: cycles at the start of each slot during which all anodes are off; must be ≥ 0.
- ACTIVE_LOW, default 1: 1 means SEG and AN are driven low-active (common-anode board); 0 means high-active.
- BLANK_LZ, default 1: enables leading-zero blanking.
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- CNT1  input  4  ones digit, BCD.
- CNT2  input  4  tens digit, BCD.
- CNT3  input  4  hundreds digit, BCD.
- SEG  output  7  segments {g,f,e,d,c,b,a}, bit0 = a; polarity per ACTIVE_LOW.
- AN  output  3  digit strobes; AN[0] = ones, AN[1] = tens, AN[2] = hundreds; polarity per ACTIVE_LOW.
- FRAME  output  1  one-cycle high pulse at each frame start; always active-high.

## Operation
- State:
  - prescaler PS runs 0..SCAN_DIV-1, width $clog2(SCAN_DIV);
  - slot index IDX cycles 0 → 1 → 2 → 0;
  - snapshot registers S1, S2, S3 (4 bits each).
- Advance rules:
  - PS increments every cycle.
  - At PS = SCAN_DIV-1, PS wraps to 0 and IDX advances; IDX 2 wraps to 0.
- Snapshot: when PS = 0 and IDX = 0 (frame start), S1..S3 load CNT1..CNT3. This includes the first cycle after reset. Input changes mid-frame are not shown until the next frame.
- Digit selection: the digit shown in a slot is S(IDX+1).
- Decode (logical, active-high): 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66, 5 = 0x6D, 6 = 0x7D, 7 = 0x07, 8 = 0x7F, 9 = 0x6F. Codes 10..15 decode to dash 0x40.
- Leading-zero blanking, when BLANK_LZ = 1:
  - S3 is blanked (0x00) if S3 = 0.
  - S2 is blanked if S3 = 0 and S2 = 0.
  - S1 is never blanked, so 000 displays "0".
  - An invalid code is nonzero and therefore never blanked.
- Dead time: while PS < DEAD, AN is all inactive and SEG is blank. Otherwise AN[IDX] is active and SEG carries the decoded digit.
- Polarity: when ACTIVE_LOW = 1, SEG and AN are bitwise inverted at the output register; FRAME is not affected.
- RESET (any time, including mid-slot): PS = 0, IDX = 0, S1..S3 = 0, FRAME = 0. AN is all inactive and SEG is blank (both in physical polarity, i.e. 3'b111 / 7'h7F when ACTIVE_LOW = 1). Scanning restarts cleanly from slot 0.

## Timing
- SEG, AN and FRAME are registered and reflect the state of the previous cycle (latency 1).
- Reference points: let t0 be the first cycle with RESET low, where PS = 0, IDX = 0 and the snapshot loads.
  - FRAME = 1 during cycle t0+1 only.
  - Outputs during t0+1 .. t0+DEAD are dead (all off).
  - AN[0] first becomes active at cycle t0+DEAD+1 and stays active through t0+SCAN_DIV.
  - AN[1] becomes active at t0+SCAN_DIV+DEAD+1.
- Frame period is 3·SCAN_DIV cycles; FRAME pulses every 3·SCAN_DIV cycles.
- Anode rules:
  - At most one AN bit is active in any cycle.
  - With DEAD ≥ 1, no two distinct AN bits are ever active in adjacent cycles.
  - DEAD = 0 is legal and gives back-to-back slots.
- Snapshot vs. display: an input change at cycle t appears on the bus no earlier than the next frame start +1.

## Structure
- Shared package seg7_pkg holds:
  - SEG_0..SEG_9, SEG_DASH (0x40), SEG_BLANK (0x00) as 7-bit logical patterns;
  - NUM_DIGITS = 3.
- Sub-module bcd_to_seg7 is a purely combinational decoder: 4-bit code plus a blank flag in, 7-bit logical pattern out. It is instantiated once, fed by the IDX mux.
- Top level contains PS, IDX, the snapshot, the blanking logic, the dead-time gate, the polarity inversion and the output registers.

## Test plan
All scenarios use SCAN_DIV = 8, DEAD = 2, ACTIVE_LOW = 1 unless stated.
- Reset: hold RESET 3 cycles with CNT = 1/2/3. While RESET is high and on the cycle after it falls, AN = 3'b111, SEG = 7'h7F, FRAME = 0. FRAME pulses at t0+1; AN = 3'b110 from t0+3 to t0+8.
- Scan order: CNT1..3 = 5, 2, 9. Across one frame, AN[0] shows ~0x6D, AN[1] shows ~0x5B, AN[2] shows ~0x6F. Each slot is lit 6 cycles and dark 2 cycles, and FRAME period is 24 cycles.
- Leading-zero blanking: CNT = 7, 0, 0 gives SEG = ~0x00 in slots 2 and 1 and ~0x07 in slot 0. CNT = 0, 0, 0 lights only slot 0 with ~0x3F. CNT = 0, 0, 4 shows "400". With BLANK_LZ = 0, CNT = 7, 0, 0 shows "007".
- Invalid code: CNT2 = 4'hA gives ~0x40 in slot 1.
- Snapshot coherence: change CNT1 from 3 to 8 during slot 1. Slot 0 of the current frame already showed 3; the change appears only after the next FRAME pulse.
- Reset mid-slot: assert RESET while AN[1] is active (PS = 5). On the next cycle outputs are all off. After release, scanning restarts at slot 0 with t0 timing as in the reset scenario. Also check ACTIVE_LOW = 0 gives non-inverted SEG and AN with the same timing.
